fb_mem_arbiter: RTL and testbench

FB_MEM_ARBITER -- requirements
Module: fb_mem_arbiter

---
 rtl/fb_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_fb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// Three-way round-robin frame-buffer memory arbiter with a registered
// command stage and an in-order read-tag queue for response routing.
module fb_mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 32,
  parameter int RQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  req_valid,
  input  logic [2:0]                  req_we,
  input  logic [3*ADDR_W-1:0]         req_addr,
  input  logic [3*DATA_W-1:0]         req_wdata,
  output logic [2:0]                  req_ready,
  output logic                        mem_valid,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [2:0]                  rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(RQ_DEPTH):0]   rd_outstanding,
  output logic                        err
);

  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]        rr, sel, nxt, off;
  logic [2:0]        elig, rot, sum;
  logic              any, free, acc, push, pop, full;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        q [RQ_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;

  assign full = (cnt == CW'(RQ_DEPTH));
  assign free = !mem_valid || mem_ready;
  assign elig = req_valid & (req_we | {3{!full}});

  // rotate so that bit 0 is the requester currently holding priority
  always_comb begin
    rot = elig;
    unique case (rr)
      2'd1:    rot = {elig[0], elig[2], elig[1]};
      2'd2:    rot = {elig[1], elig[0], elig[2]};
      default: rot = elig;
    endcase
  end

  always_comb begin
    off = rot[0] ? 2'd0 : (rot[1] ? 2'd1 : 2'd2);
    any = |rot;
    sum = {1'b0, rr} + {1'b0, off};
    sel = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    nxt = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  end

  assign req_ready = (any && free && !rst) ? (3'b001 << sel) : 3'b000;
  assign acc  = |req_ready;

  always_comb begin
    sel_we    = req_we[0];
    sel_addr  = req_addr[0 +: ADDR_W];
    sel_wdata = req_wdata[0 +: DATA_W];
    unique case (sel)
      2'd1: begin
        sel_we    = req_we[1];
        sel_addr  = req_addr[ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_we    = req_we[2];
        sel_addr  = req_addr[2*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  assign push = acc && !sel_we;
  assign pop  = mem_rvalid && (cnt != '0);
  assign rd_outstanding = cnt;

  always_ff @(posedge clk) begin
    if (push) q[wp] <= sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr        <= 2'd0;
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      rsp_valid <= 3'b000;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      if (free) mem_valid <= acc;
      if (acc) begin
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        rr        <= nxt;
      end
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      rsp_valid <= pop ? (3'b001 << q[rp]) : 3'b000;
      if (pop) rsp_data <= mem_rdata;
      if (mem_rvalid && cnt == '0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_fb_mem_arbiter;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int D  = 4;

  logic            clk, rst;
  logic [2:0]      req_valid, req_we, req_ready;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic            mem_valid, mem_we, mem_ready, mem_rvalid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata, rsp_data;
  logic [2:0]      rsp_valid;
  logic [2:0]      rd_outstanding;
  logic            err;

  fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rd_outstanding(rd_outstanding), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int            m_rr;
  bit            m_mv, m_mwe, m_err;
  logic [AW-1:0] m_maddr;
  logic [DW-1:0] m_mwd, m_rspd;
  logic [2:0]    m_rspv;
  int            q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_rr = 0; m_mv = 0; m_mwe = 0; m_err = 0;
    m_maddr = '0; m_mwd = '0; m_rspd = '0; m_rspv = '0;
    q.delete();
  endtask

  function automatic int m_grant();
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_rr + k) % 3;
      if (req_valid[i] && (req_we[i] || q.size() < D)) return i;
    end
    return -1;
  endfunction

  task automatic m_edge();
    int g, h;
    bit fr, ac;
    g  = m_grant();
    fr = !m_mv || mem_ready;
    ac = fr && (g >= 0);
    m_rspv = 3'b000;
    if (mem_rvalid) begin
      if (q.size() > 0) begin
        h = q.pop_front();
        m_rspv = 3'(1 << h);
        m_rspd = mem_rdata;
      end else m_err = 1;
    end
    if (ac) begin
      if (!req_we[g]) q.push_back(g);
      m_rr    = (g + 1) % 3;
      m_mwe   = req_we[g];
      m_maddr = req_addr[g*AW +: AW];
      m_mwd   = req_wdata[g*DW +: DW];
    end
    if (fr) m_mv = ac;
  endtask

  task automatic chk_regs();
    chk("mem_valid", 64'(mem_valid), 64'(m_mv));
    chk("mem_we", 64'(mem_we), 64'(m_mwe));
    chk("mem_addr", 64'(mem_addr), 64'(m_maddr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_mwd));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
    chk("rsp_data", 64'(rsp_data), 64'(m_rspd));
    chk("rd_outstanding", 64'(rd_outstanding), 64'(q.size()));
    chk("err", 64'(err), 64'(m_err));
  endtask

  // one clock: check combinational grant, step model at the edge, check regs
  task automatic cycle(output logic [2:0] seen);
    int g;
    logic [2:0] er;
    #1;
    g  = m_grant();
    er = ((g >= 0) && (!m_mv || mem_ready)) ? 3'(1 << g) : 3'b000;
    seen = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    m_edge();
    #1;
    chk_regs();
  endtask

  task automatic drv(input logic [2:0] v, input logic [2:0] we,
                     input logic r, input logic rv);
    req_valid = v; req_we = we; mem_ready = r; mem_rvalid = rv;
    mem_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*AW +: AW]  = AW'($urandom);
      req_wdata[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [2:0]    seen;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  logic [2:0]    gexp [4];

  initial begin
    rst = 1'b0;
    drv(3'b111, 3'b000, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ready_async", 64'(req_ready), 64'(0));
    chk_regs();
    @(posedge clk);
    #1;
    chk("rst_ready_held", 64'(req_ready), 64'(0));
    chk_regs();
    rst = 1'b0;

    // round-robin over three readers
    drv(3'b111, 3'b000, 1'b1, 1'b0);
    gexp[0] = 3'b001; gexp[1] = 3'b010; gexp[2] = 3'b100; gexp[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      cycle(seen);
      chk("rr_grant", 64'(seen), 64'(gexp[i]));
      chk("rr_addr", 64'(mem_addr), 64'(req_addr[(i%3)*AW +: AW]));
    end

    // read queue fills; writes still flow
    do_reset();
    drv(3'b010, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(seen);
      chk("fill_grant", 64'(seen), 64'(3'b010));
    end
    chk("fill_count", 64'(rd_outstanding), 64'(4));
    drv(3'b011, 3'b001, 1'b1, 1'b0);
    cycle(seen);
    chk("full_write_only", 64'(seen), 64'(3'b001));

    // memory backpressure holds the command
    do_reset();
    drv(3'b001, 3'b001, 1'b1, 1'b0);
    cycle(seen);
    hold_a = mem_addr;
    hold_d = mem_wdata;
    drv(3'b111, 3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(seen);
      chk("stall_ready", 64'(seen), 64'(0));
      chk("stall_addr", 64'(mem_addr), 64'(hold_a));
      chk("stall_wdata", 64'(mem_wdata), 64'(hold_d));
    end
    mem_ready = 1'b1;
    cycle(seen);
    chk("resume_grant", 64'(seen), 64'(3'b010));

    // responses routed in order
    do_reset();
    drv(3'b100, 3'b000, 1'b1, 1'b0);
    cycle(seen);
    drv(3'b010, 3'b000, 1'b1, 1'b0);
    cycle(seen);
    drv(3'b000, 3'b000, 1'b1, 1'b1);
    mem_rdata = 32'h0000_AAAA;
    cycle(seen);
    chk("rsp0_valid", 64'(rsp_valid), 64'(3'b100));
    chk("rsp0_data", 64'(rsp_data), 64'(32'h0000_AAAA));
    mem_rdata = 32'h0000_5555;
    cycle(seen);
    chk("rsp1_valid", 64'(rsp_valid), 64'(3'b010));
    chk("rsp1_data", 64'(rsp_data), 64'(32'h0000_5555));

    // unexpected return is sticky
    cycle(seen);
    chk("err_set", 64'(err), 64'(1));
    chk("err_no_rsp", 64'(rsp_valid), 64'(0));
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) cycle(seen);
    chk("err_sticky", 64'(err), 64'(1));
    do_reset();
    chk("err_cleared", 64'(err), 64'(0));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drv(3'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      mem_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      cycle(seen);
    end

    // reset with reads outstanding
    do_reset();
    drv(3'b010, 3'b000, 1'b1, 1'b0);
    cycle(seen);
    cycle(seen);
    drv(3'b000, 3'b000, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_count", 64'(rd_outstanding), 64'(0));
    chk("midrst_valid", 64'(mem_valid), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(0));
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv(3'b000, 3'b000, 1'b1, 1'b1);
    cycle(seen);
    chk("postrst_err", 64'(err), 64'(1));
    drv(3'b111, 3'b000, 1'b1, 1'b0);
    cycle(seen);
    chk("postrst_grant", 64'(seen), 64'(3'b001));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
